// File: rtl/ahb_uart_loader_if.sv
// AHB-Lite write-master signal bundle used between ahb_uart_loader and the bus mux.
interface ahb_uart_loader_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADY
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADY
  );
endinterface

// File: rtl/ahb_uart_loader.sv
// UART-fed AHB-Lite loader: 8N1 receiver, write-packet parser, single-word write master.
// Define LOADER_CHECKSUM_EN to append and check an 8-bit CSUM byte after the data bytes.
module ahb_uart_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              RX,
  ahb_uart_loader_if.master bus,
  output logic              HOLD,
  output logic              ERR,
  output logic [7:0]        dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    P_SYNC, P_CMD, P_ADDR0, P_ADDR1, P_ADDR2, P_ADDR3, P_CNT, P_DATA
`ifdef LOADER_CHECKSUM_EN
    , P_CSUM
`endif
  } p_state_t;
  typedef enum logic [1:0] {A_IDLE, A_ADDR, A_DATA} a_state_t;

  rx_state_t rx_st, rx_nxt;
  p_state_t  p_st, p_nxt;
  a_state_t  a_st, a_nxt;

  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          rx_tick, byte_vld, frame_err;

  logic [31:0] addr, req_addr, req_data, xfer_addr, xfer_data;
  logic [23:0] word_buf;
  logic [8:0]  words_left;
  logic [1:0]  byte_idx;
  logic        req_vld, hold, err, drop_pend;
  logic        overrun, last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // ---------------- UART receiver ----------------
  always_comb begin
    rx_nxt  = rx_st;
    rx_tick = (rx_cnt == ((rx_st == RX_START) ? HALF_CNT : FULL_CNT));
    case (rx_st)
      RX_IDLE:  if (rx_s3 && !rx_s2) rx_nxt = RX_START;
      RX_START: if (rx_tick) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && bit_idx == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_st     <= RX_IDLE;
      rx_cnt    <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= RX;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      rx_st     <= rx_nxt;
      rx_cnt    <= (rx_st == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      byte_vld  <= (rx_st == RX_STOP) && rx_tick && rx_s2;
      frame_err <= (rx_st == RX_STOP) && rx_tick && !rx_s2;
      if (rx_st == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end else if (rx_st != RX_DATA) begin
        bit_idx <= '0;
      end
    end
  end

  // ---------------- packet parser ----------------
  // Handshake: req_vld is raised by the parser and held until the AHB FSM takes
  // req_addr/req_data in A_IDLE; a word completing while a request is staged or
  // a transfer is in flight is an overrun.
  assign overrun   = req_vld || (a_st != A_IDLE);
  assign last_word = (words_left == 9'd1);

  always_comb begin
    p_nxt = p_st;
    if (frame_err) begin
      p_nxt = P_SYNC;
    end else if (byte_vld) begin
      case (p_st)
        P_SYNC:  if (rx_shift == 8'hA5) p_nxt = P_CMD;
        P_CMD:   p_nxt = (rx_shift == 8'h01) ? P_ADDR0 : P_SYNC;
        P_ADDR0: p_nxt = P_ADDR1;
        P_ADDR1: p_nxt = P_ADDR2;
        P_ADDR2: p_nxt = P_ADDR3;
        P_ADDR3: p_nxt = P_CNT;
        P_CNT:   p_nxt = P_DATA;
        P_DATA: begin
          if (byte_idx == 2'd3) begin
            if (overrun) p_nxt = P_SYNC;
`ifdef LOADER_CHECKSUM_EN
            else if (last_word) p_nxt = P_CSUM;
`else
            else if (last_word) p_nxt = P_SYNC;
`endif
          end
        end
        default: p_nxt = P_SYNC;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      p_st       <= P_SYNC;
      addr       <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      req_vld    <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      hold       <= 1'b0;
      err        <= 1'b0;
      drop_pend  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      p_st <= p_nxt;
      if (req_vld && a_st == A_IDLE) req_vld <= 1'b0;
      // HOLD drops once nothing is staged and the last beat is retiring.
      if (drop_pend && !req_vld && (a_st == A_IDLE || (a_st == A_DATA && bus.HREADY))) begin
        hold      <= 1'b0;
        drop_pend <= 1'b0;
      end
      if (frame_err) begin
        err       <= 1'b1;
        drop_pend <= drop_pend | hold;
      end else if (byte_vld) begin
`ifdef LOADER_CHECKSUM_EN
        if (p_st != P_SYNC && p_st != P_CSUM) csum <= csum + rx_shift;
`endif
        case (p_st)
          P_SYNC: if (rx_shift == 8'hA5) err <= 1'b0;
          P_CMD: begin
            if (rx_shift == 8'h01) begin
              hold      <= 1'b1;
              drop_pend <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
              csum      <= 8'h01;
`endif
            end else begin
              err <= 1'b1;
            end
          end
          P_ADDR0: addr[7:0]   <= {rx_shift[7:2], 2'b00};
          P_ADDR1: addr[15:8]  <= rx_shift;
          P_ADDR2: addr[23:16] <= rx_shift;
          P_ADDR3: addr[31:24] <= rx_shift;
          P_CNT: begin
            words_left <= (rx_shift == 8'h00) ? 9'd256 : {1'b0, rx_shift};
            byte_idx   <= 2'd0;
          end
          P_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx != 2'd3) begin
              word_buf[{byte_idx, 3'b000} +: 8] <= rx_shift;
            end else if (overrun) begin
              err       <= 1'b1;
              drop_pend <= 1'b1;
            end else begin
              req_vld    <= 1'b1;
              req_addr   <= addr;
              req_data   <= {rx_shift, word_buf};
              addr       <= addr + 32'd4;
              words_left <= words_left - 9'd1;
`ifndef LOADER_CHECKSUM_EN
              if (last_word) drop_pend <= 1'b1;
`endif
            end
          end
`ifdef LOADER_CHECKSUM_EN
          P_CSUM: begin
            if (rx_shift != csum) err <= 1'b1;
            if (!req_vld && a_st == A_IDLE) hold <= 1'b0;
            else drop_pend <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // ---------------- AHB-Lite write master ----------------
  always_comb begin
    a_nxt = a_st;
    case (a_st)
      A_IDLE:  if (req_vld) a_nxt = A_ADDR;
      A_ADDR:  if (bus.HREADY) a_nxt = A_DATA;
      A_DATA:  if (bus.HREADY) a_nxt = A_IDLE;
      default: a_nxt = A_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_st      <= A_IDLE;
      xfer_addr <= '0;
      xfer_data <= '0;
    end else begin
      a_st <= a_nxt;
      if (a_st == A_IDLE && req_vld) begin
        xfer_addr <= req_addr;
        xfer_data <= req_data;
      end
    end
  end

  assign bus.HADDR  = xfer_addr;
  assign bus.HTRANS = (a_st == A_ADDR) ? 2'b10 : 2'b00;
  assign bus.HWRITE = (a_st == A_ADDR);
  assign bus.HSIZE  = 3'b010;
  assign bus.HWDATA = xfer_data;
  assign HOLD       = hold;
  assign ERR        = err;
  assign dbg_state  = {rx_st, p_st, a_st};

endmodule

// File: tb/tb_ahb_uart_loader.sv
// Bench for ahb_uart_loader: UART byte driver, AHB write scoreboard, directed packets.
module tb_ahb_uart_loader;
  localparam int CPB = 8;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       RX;
  logic       HOLD, ERR;
  logic [7:0] dbg_state;

  ahb_uart_loader_if bus ();

  ahb_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .RX(RX), .bus(bus),
    .HOLD(HOLD), .ERR(ERR), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];   // {last, addr, data}
  logic        stall_arm = 1'b0;
  logic [31:0] stall_exp = '0;
  logic        mon_data_ph = 1'b0;
  logic        hold_chk = 1'b0;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_xor = 8'h00;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bit_time();
    repeat (CPB) @(posedge HCLK);
    #1;
  endtask

  task automatic uart_byte(input logic [7:0] b, input bit bad_stop);
    RX = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      bit_time();
    end
    RX = bad_stop ? 1'b0 : 1'b1;
    bit_time();
    RX = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  task automatic send_packet(input logic [31:0] addr, input logic [31:0] w0,
                             input logic [31:0] w1, input bit with_sync);
    logic [31:0] a;
    logic [7:0]  cs;
    logic [7:0]  body[$];
    logic        last_flag;
    a = addr & 32'hFFFF_FFFC;
`ifdef LOADER_CHECKSUM_EN
    last_flag = 1'b0;
`else
    last_flag = 1'b1;
`endif
    exp_q.push_back({1'b0, a, w0});
    exp_q.push_back({last_flag, a + 32'd4, w1});
    body = '{addr[7:0], addr[15:8], addr[23:16], addr[31:24], 8'h02,
             w0[7:0], w0[15:8], w0[23:16], w0[31:24],
             w1[7:0], w1[15:8], w1[23:16], w1[31:24]};
    if (with_sync) uart_byte(8'hA5, 1'b0);
    uart_byte(8'h01, 1'b0);
    check("hold_after_cmd", 32'(HOLD), 32'd1);
    cs = 8'h01;
    foreach (body[i]) begin
      uart_byte(body[i], 1'b0);
      cs = cs + body[i];
    end
`ifdef LOADER_CHECKSUM_EN
    uart_byte(cs ^ csum_xor, 1'b0);
    check("hold_after_csum", 32'(HOLD), 32'd0);
`endif
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || mon_data_ph || hold_chk) && t < 3000) begin
      @(posedge HCLK);
      t++;
    end
    #1;
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: %0d writes outstanding, expected 0", nm, exp_q.size());
    end
    repeat (4) @(posedge HCLK);
    #1;
  endtask

  // ---------------- HREADY driver with address-phase stall ----------------
  initial begin
    logic stall_used;
    stall_used = 1'b0;
    bus.HREADY = 1'b1;
    forever begin
      @(posedge HCLK);
      #2;
      if (stall_arm && !stall_used && bus.HTRANS == 2'b10) begin
        stall_used = 1'b1;
        bus.HREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
          check("stall_haddr", bus.HADDR, stall_exp);
          check("stall_htrans", 32'(bus.HTRANS), 32'h2);
          @(posedge HCLK);
          #2;
        end
        bus.HREADY = 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [64:0] cur;
    cur = '0;
    forever begin
      @(negedge HCLK);
      if (HRESETn) begin
        if (hold_chk) begin
          check("hold_low_after_last", 32'(HOLD), 32'd0);
          hold_chk = 1'b0;
        end
        if (mon_data_ph && bus.HREADY) begin
          check("hwdata", bus.HWDATA, cur[31:0]);
          if (cur[64]) begin
            check("hold_in_last_data", 32'(HOLD), 32'd1);
            hold_chk = 1'b1;
          end
          mon_data_ph = 1'b0;
        end
        if (bus.HTRANS == 2'b10 && bus.HREADY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%08h seen, no write expected", bus.HADDR);
          end else begin
            cur = exp_q.pop_front();
            check("haddr", bus.HADDR, cur[63:32]);
            check("hwrite", 32'(bus.HWRITE), 32'd1);
            check("hsize", 32'(bus.HSIZE), 32'd2);
            mon_data_ph = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    HRESETn = 1'b0;
    RX = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge HCLK);
      #1;
      RX = ~RX;
    end
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_htrans", 32'(bus.HTRANS), 32'h0);
    check("rst_hwrite", 32'(bus.HWRITE), 32'h0);
    check("rst_hsize", 32'(bus.HSIZE), 32'h2);
    check("rst_hwdata", bus.HWDATA, 32'h0);
    check("rst_hold", 32'(HOLD), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);
    RX = 1'b1;
    repeat (4) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (20) @(posedge HCLK);
    #1;

    // basic two-word load
    send_packet(32'h2000_0000, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1);
    wait_idle("pkt_a");
    check("pkt_a_err", 32'(ERR), 32'h0);
    check("pkt_a_hold_end", 32'(HOLD), 32'h0);

    // first address phase stalled for 5 cycles
    stall_exp = 32'h2000_0000;
    stall_arm = 1'b1;
    send_packet(32'h2000_0000, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1);
    wait_idle("pkt_stall");
    stall_arm = 1'b0;
    check("stall_err", 32'(ERR), 32'h0);

    // address alignment and wrap
    send_packet(32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0123_4567, 1'b1);
    wait_idle("pkt_wrap");
    check("wrap_err", 32'(ERR), 32'h0);

    // bad command, then resync on the next sync byte
    uart_byte(8'hA5, 1'b0);
    uart_byte(8'h07, 1'b0);
    check("badcmd_err", 32'(ERR), 32'h1);
    check("badcmd_hold", 32'(HOLD), 32'h0);
    uart_byte(8'hA5, 1'b0);
    check("badcmd_err_cleared", 32'(ERR), 32'h0);
    send_packet(32'h1000_0010, 32'hA5A5_0101, 32'h5A5A_FFFF, 1'b0);
    wait_idle("pkt_after_badcmd");

    // framing error on the third byte, then a clean packet
    uart_byte(8'hA5, 1'b0);
    uart_byte(8'h01, 1'b0);
    uart_byte(8'h40, 1'b1);
    check("frame_err", 32'(ERR), 32'h1);
    repeat (10) @(posedge HCLK);
    #1;
    send_packet(32'h3000_0040, 32'h0BAD_CAFE, 32'h7654_3210, 1'b1);
    wait_idle("pkt_after_frame");
    check("frame_err_cleared", 32'(ERR), 32'h0);

`ifdef LOADER_CHECKSUM_EN
    // wrong checksum: writes still land, ERR raised afterwards
    csum_xor = 8'hFF;
    send_packet(32'h4000_0000, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1);
    wait_idle("pkt_bad_csum");
    check("csum_err", 32'(ERR), 32'h1);
    csum_xor = 8'h00;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
